// File: rtl/panzer_pkg.sv
// Shared definitions for the PANZER16 ALU: opcodes, datapath width and
// status-word bit positions.
package panzer_pkg;

    localparam int WIDTH = 16;

    localparam logic [3:0] OP_PASSA = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_ADC   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_ASR   = 4'b1010;
    localparam logic [3:0] OP_ROL   = 4'b1011;
    localparam logic [3:0] OP_ROR   = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    localparam int STAT_Z = 0;
    localparam int STAT_C = 1;

    // Only these three opcodes are allowed to raise Z or C.
    function automatic logic is_flag_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/panzer_alu_if.sv
// Control-unit <-> ALU bus: operation request in, registered result/flags out.
interface panzer_alu_if;
    import panzer_pkg::*;

    logic             OutputSel;
    logic [3:0]       Instruction;
    logic             CarryIn;
    logic [WIDTH-1:0] DataIn1;
    logic [WIDTH-1:0] DataIn2;
    logic             Done;
    logic             Z;
    logic             C;
    logic [WIDTH-1:0] DataOut;

    modport master (
        output OutputSel, Instruction, CarryIn, DataIn1, DataIn2,
        input  Done, Z, C, DataOut
    );

    modport slave (
        input  OutputSel, Instruction, CarryIn, DataIn1, DataIn2,
        output Done, Z, C, DataOut
    );

endinterface

// File: rtl/panzer_alu_core.sv
// Combinational ALU datapath: opcode decode, 17-bit arithmetic, logic and
// shift operations, plus next-state zero/carry flags.
module panzer_alu_core
    import panzer_pkg::*;
(
    input  logic [3:0]       i_op,
    input  logic             i_carry,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_z,
    output logic             o_c
);

    logic [WIDTH:0] w_wide;
    logic [WIDTH:0] w_a;
    logic [WIDTH:0] w_b;
    logic           w_flag_op;

    assign w_a = {1'b0, i_a};
    assign w_b = {1'b0, i_b};

    // Bit WIDTH of the subtraction is the borrow: set exactly when A < B.
    always_comb begin
        w_wide = '0;
        case (i_op)
            OP_PASSA: w_wide = w_a;
            OP_SUB:   w_wide = w_a - w_b;
            OP_ADC:   w_wide = w_a + w_b + {{WIDTH{1'b0}}, i_carry};
            OP_AND:   w_wide = w_a & w_b;
            OP_OR:    w_wide = w_a | w_b;
            OP_XOR:   w_wide = w_a ^ w_b;
            OP_NOT:   w_wide = {1'b0, ~i_a};
            OP_SHL:   w_wide = {1'b0, i_a[WIDTH-2:0], 1'b0};
            OP_ADD:   w_wide = w_a + w_b;
            OP_SHR:   w_wide = {2'b00, i_a[WIDTH-1:1]};
            OP_ASR:   w_wide = {1'b0, i_a[WIDTH-1], i_a[WIDTH-1:1]};
            OP_ROL:   w_wide = {1'b0, i_a[WIDTH-2:0], i_a[WIDTH-1]};
            OP_ROR:   w_wide = {1'b0, i_a[0], i_a[WIDTH-1:1]};
            OP_INC:   w_wide = w_a + (WIDTH+1)'(1);
            OP_DEC:   w_wide = w_a - (WIDTH+1)'(1);
            OP_PASSB: w_wide = w_b;
            default:  w_wide = '0;
        endcase
    end

    assign w_flag_op = is_flag_op(i_op);
    assign o_result  = w_wide[WIDTH-1:0];
    assign o_z       = w_flag_op && (w_wide[WIDTH-1:0] == '0);
    assign o_c       = w_flag_op && w_wide[WIDTH];

endmodule

// File: rtl/panzer_alu.sv
// PANZER16 ALU top: one-cycle registered result and flags, Done flag and
// the combinational result/status output mux.
module panzer_alu
    import panzer_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst_n,
    panzer_alu_if.slave  bus
);

    logic [WIDTH-1:0] w_result;
    logic             w_z;
    logic             w_c;
    logic [WIDTH-1:0] w_status;

    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_c;
    logic             r_done;

    panzer_alu_core u_core (
        .i_op     (bus.Instruction),
        .i_carry  (bus.CarryIn),
        .i_a      (bus.DataIn1),
        .i_b      (bus.DataIn2),
        .o_result (w_result),
        .o_z      (w_z),
        .o_c      (w_c)
    );

    // A new op is accepted every cycle; Done only marks that reset has been left.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_result <= w_result;
            r_z      <= w_z;
            r_c      <= w_c;
            r_done   <= 1'b1;
        end
    end

    always_comb begin
        w_status         = '0;
        w_status[STAT_Z] = r_z;
        w_status[STAT_C] = r_c;
    end

    assign bus.DataOut = bus.OutputSel ? w_status : r_result;
    assign bus.Z       = r_z;
    assign bus.C       = r_c;
    assign bus.Done    = r_done;

endmodule

// File: tb/tb_panzer_alu.sv
// Scoreboard bench for panzer_alu: stimulus pushes model results, a monitor
// pops and compares one cycle after each accepted op.
module tb_panzer_alu;
    import panzer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    panzer_alu_if bus();

    panzer_alu dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] res;
        logic        z;
        logic        c;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    logic issue_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on the opcode meanings.
    function automatic exp_t model(input logic [3:0] op, input int unsigned a,
                                   input int unsigned b, input int unsigned cin);
        exp_t        e;
        int unsigned r;
        int unsigned s;
        bit          c;
        bit          flags;
        r = 0; c = 0; flags = 0; s = 0;
        case (op)
            4'd0:  r = a;
            4'd1:  begin r = (a + 65536 - b) % 65536; c = (a < b); flags = 1; end
            4'd2:  begin s = a + b + cin; r = s % 65536; c = (s > 65535); flags = 1; end
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd6:  r = 65535 - a;
            4'd7:  r = (a * 2) % 65536;
            4'd8:  begin s = a + b; r = s % 65536; c = (s > 65535); flags = 1; end
            4'd9:  r = a / 2;
            4'd10: r = a / 2 + ((a >= 32768) ? 32768 : 0);
            4'd11: r = (a * 2) % 65536 + a / 32768;
            4'd12: r = a / 2 + (a % 2) * 32768;
            4'd13: r = (a + 1) % 65536;
            4'd14: r = (a + 65535) % 65536;
            default: r = b;
        endcase
        e.op  = op;
        e.res = r[15:0];
        e.z   = flags && (r == 0);
        e.c   = c;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sel);
        @(negedge clk);
        bus.Instruction = op;
        bus.DataIn1     = a;
        bus.DataIn2     = b;
        bus.CarryIn     = cin;
        bus.OutputSel   = sel;
        issue_v         = 1'b1;
        sb_q.push_back(model(op, a, b, cin));
    endtask

    // Monitor: an op present at a non-reset rising edge is due one edge later.
    initial begin
        bit          took;
        exp_t        e;
        logic [15:0] exp_out;
        forever begin
            @(posedge clk);
            took = issue_v && rst_n;
            #1;
            if (took) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got output with empty queue, expected queued entry");
                end else begin
                    e = sb_q.pop_front();
                    exp_out = bus.OutputSel ? {14'b0, e.c, e.z} : e.res;
                    chk($sformatf("op%0d done", e.op), {31'b0, bus.Done}, 32'd1);
                    chk($sformatf("op%0d Z", e.op), {31'b0, bus.Z}, {31'b0, e.z});
                    chk($sformatf("op%0d C", e.op), {31'b0, bus.C}, {31'b0, e.c});
                    chk($sformatf("op%0d DataOut sel%0d", e.op, bus.OutputSel),
                        {16'b0, bus.DataOut}, {16'b0, exp_out});
                    $display("op=%h res=%h Z=%b C=%b sel=%b", e.op, bus.DataOut, bus.Z, bus.C, bus.OutputSel);
                end
            end
        end
    end

    initial begin
        bus.Instruction = 4'($urandom);
        bus.DataIn1     = 16'($urandom);
        bus.DataIn2     = 16'($urandom);
        bus.CarryIn     = 1'($urandom);
        bus.OutputSel   = 1'b0;

        // Reset held across an edge with random inputs present.
        #12;
        chk("reset DataOut sel0", {16'b0, bus.DataOut}, 32'd0);
        chk("reset Z", {31'b0, bus.Z}, 32'd0);
        chk("reset C", {31'b0, bus.C}, 32'd0);
        chk("reset Done", {31'b0, bus.Done}, 32'd0);
        bus.OutputSel = 1'b1;
        #1;
        chk("reset DataOut sel1", {16'b0, bus.DataOut}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.OutputSel = 1'b0;
        @(posedge clk);
        #1;
        chk("Done after release", {31'b0, bus.Done}, 32'd1);

        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(OP_ADD, 16'h1234, 16'h0001, 1'b1, 1'b0);
        issue(OP_SUB, 16'h0005, 16'h0007, 1'b1, 1'b0);
        issue(OP_SUB, 16'h00AA, 16'h00AA, 1'b0, 1'b0);
        issue(OP_ADC, 16'h0001, 16'h0001, 1'b1, 1'b0);
        issue(OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(OP_XOR, 16'h5555, 16'h5555, 1'b1, 1'b0);
        issue(OP_DEC, 16'h0001, 16'h0000, 1'b0, 1'b0);
        issue(OP_INC, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);

        // Idle between edges: flip OutputSel and watch DataOut follow.
        @(negedge clk);
        issue_v = 1'b0;
        #1;
        bus.OutputSel = 1'b1;
        #1;
        chk("OutputSel=1 status", {16'b0, bus.DataOut}, 32'h0003);
        bus.OutputSel = 1'b0;
        #1;
        chk("OutputSel=0 result", {16'b0, bus.DataOut}, 32'h0000);

        // Reset asserted while an op is waiting for its edge.
        issue(OP_OR, 16'h1234, 16'h4321, 1'b0, 1'b0);
        #2;
        rst_n   = 1'b0;
        issue_v = 1'b0;
        void'(sb_q.pop_back());
        #1;
        chk("midreset DataOut", {16'b0, bus.DataOut}, 32'd0);
        chk("midreset Z", {31'b0, bus.Z}, 32'd0);
        chk("midreset C", {31'b0, bus.C}, 32'd0);
        chk("midreset Done", {31'b0, bus.Done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_ADD, 16'h0001, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        issue_v = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/panzer_alu.md
Name: panzer_alu

Overview:
- 16-bit arithmetic/logic unit of the PANZER16 CPU datapath, driven by the control unit with a 4-bit operation code and two 16-bit operands.
- Produces a registered 16-bit result, a zero flag (Z) and a carry flag (C).
- Flags are produced only by the three arithmetic ops ADD, ADC and SUB; all other ops force Z=C=0.
- One-cycle latency; Done marks that the output register holds a valid result.

Parameters:
- WIDTH, 16: operand/result width. Only 16 is supported.

Ports:
- Clk  input  1  system clock, rising-edge active
- Rst_n  input  1  asynchronous, active-low reset
- OutputSel  input  1  0: DataOut = result register; 1: DataOut = status word {14'b0, C, Z}
- Instruction  input  4  operation code (map below)
- CarryIn  input  1  carry input, used by ADC only
- DataIn1  input  16  operand A
- DataIn2  input  16  operand B
- Done  output  1  result register valid
- Z  output  1  zero flag, registered
- C  output  1  carry/borrow flag, registered
- DataOut  output  16  result or status word, per OutputSel

Behaviour:
- Reset (Rst_n=0, asynchronous): result register=0, Z=0, C=0, Done=0. DataOut is 0 for either OutputSel value.
- Every rising Clk with Rst_n=1: sample Instruction, CarryIn, DataIn1, DataIn2; compute combinationally; register result, Z and C. Latency is exactly 1 cycle, and a new op is accepted every cycle.
- Done: 0 in reset; 1 from the first rising edge after reset release; stays 1 until the next reset.
- OutputSel is a purely combinational mux on the registered values. It has no effect on the registers.
- Opcode map (A=DataIn1, B=DataIn2):
  - 0000 PASSA: A
  - 0001 SUB: A-B
  - 0010 ADC: A+B+CarryIn
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 NOT A
  - 0111 SHL A by 1, fill 0
  - 1000 ADD: A+B
  - 1001 SHR A by 1, logical
  - 1010 ASR A by 1
  - 1011 ROL A by 1
  - 1100 ROR A by 1
  - 1101 INC A
  - 1110 DEC A
  - 1111 PASSB: B
- Width rules: all arithmetic is done at 17 bits; result = low 16 bits, wrapping modulo 2^16.
- Flags for ADD/ADC/SUB only:
  - Z = (16-bit result == 0)
  - ADD/ADC: C = bit 16 of the sum
  - SUB: C = borrow, i.e. 1 when A < B unsigned
- All other opcodes, including INC, DEC and the shifts: Z=0 and C=0 are registered. Flags are cleared, not held.
- CarryIn is ignored by every opcode except ADC.
- ADC with A=FFFF, B=0, CarryIn=1: result 0000, Z=1, C=1.
- Reset asserted mid-operation discards the in-flight result. The first post-reset edge loads a fresh op.

Decomposition:
- Shared package panzer_pkg holds:
  - ALU opcode localparams (OP_PASSA … OP_PASSB)
  - WIDTH = 16
  - status-word bit positions (Z=0, C=1)
- One combinational sub-module, panzer_alu_core: opcode decode, arithmetic/logic/shift, next Z/C.
- The top level holds the registers, the Done flag and the OutputSel mux.

Test Plan:
- Reset: Rst_n=0 with random inputs → DataOut=0000, Z=0, C=0, Done=0. Release Rst_n → Done=1 after the first edge.
- ADD: A=FFFF, B=0001 → next cycle DataOut=0000, Z=1, C=1. Then A=1234, B=0001 → 1235, Z=0, C=0.
- SUB/ADC: SUB A=0005, B=0007 → FFFE, C=1, Z=0. SUB A=B=00AA → 0000, Z=1, C=0. ADC A=0001, B=0001, CarryIn=1 → 0003, C=0.
- Flag clearing: ADD A=FFFF, B=0001 (Z=C=1), then XOR A=B=5555 → result 0000 with Z=0, C=0. Also DEC A=0001 → 0000, Z=0.
- OutputSel: after ADD FFFF+0001, OutputSel=1 → DataOut=0003; OutputSel=0 → 0000. Switching happens without a clock edge.
- Random regression: 200 random Instruction/A/B/CarryIn samples, each checked one cycle later against a reference model. Z or C high with an opcode outside {1000, 0010, 0001} is an error.
